vga_frame_monitor: RTL and testbench
====================================

// Module: vga_frame_monitor
// PURPOSE
// Receiving end of the TinyVGA Pmod output of tt_um_Bouncingbox. Consumes the 8-bit uo_out bus one pixel per clock,
// recovers hsync/vsync timing, checks line length and frame height against 640x480@60 parameters, and reports
// per-frame lock status and the bounding box of non-black pixels. Used as an on-chip self-check and as a bench scoreboard.
// PARAMETERS
// H_VIS 640 visible pixels/line; H_FP 16; H_SYNC 96; H_BP 48 (H_TOTAL = sum = 800)
// V_VIS 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33 (V_TOTAL = sum = 525)
// SYNC_POL 0 sync active level (0 = active-low)
// PORTS
// clk         in   1   pixel clock, one pixel per rising edge
// rst         in   1   synchronous reset, active-high
// vga_in      in   8   TinyVGA bus: [7]HS [6]B0 [5]G0 [4]R0 [3]VS [2]B1 [1]G1 [0]R1
// err_clr     in   1   clears err_hlen/err_vlen
// locked      out  1   timing matches parameters
// frame_done  out  1   1-cycle pulse when a frame closes; results below update on the same cycle
// line_len    out  11  clocks of last complete line, saturates at 2047
// frame_lines out  10  lines of last complete frame, saturates at 1023
// bbox_valid  out  1   last frame closed while locked and had >=1 non-black visible pixel
// x_min/x_max out  10  bbox columns, 0..H_VIS-1
// y_min/y_max out  10  bbox rows, 0..V_VIS-1
// err_hlen    out  1   sticky: line length mismatch while locked
// err_vlen    out  1   sticky: frame line count mismatch while locked
// BEHAVIOUR
// - Reset: every output and register 0, FSM = HUNT. Reset mid-frame discards all partial measurement.
// - Input registered once; HS/VS assert edge = transition into SYNC_POL level. Result latency: 2 clk from pin.
// - h_cnt: cleared to 0 on HS edge, else +1, saturates. x = h_cnt - (H_SYNC+H_BP), active iff 0 <= x < H_VIS.
// - v_cnt: cleared on VS edge, +1 on each HS edge, saturates. y = v_cnt - (V_SYNC+V_BP), active iff 0 <= y < V_VIS.
// - HS edge: line_len <= h_cnt+1 (only if a prior HS edge exists since HUNT entry); line_len otherwise unchanged.
// - VS edge: frame_lines <= v_cnt; frame_done pulse; bbox outputs latched from working regs; working regs
//   reset to min = all-ones, max = 0. VS edge while not locked -> bbox_valid <= 0.
// - Same-cycle HS and VS edge: HS processed first (line closed and counted), then VS closes frame.
// - Non-black = any of the six colour bits set, in active area only. Pixel updates min/max working regs.
// - FSM: HUNT -(VS edge)-> MEASURE; MEASURE -(VS edge, all lines == H_TOTAL and frame_lines == V_TOTAL)-> LOCKED,
//   else stay MEASURE (restart). LOCKED -(line_len != H_TOTAL, or h_cnt reaches H_TOTAL with no HS edge)-> HUNT,
//   err_hlen <= 1; LOCKED -(VS edge, frame_lines != V_TOTAL)-> HUNT, err_vlen <= 1. locked = (state == LOCKED),
//   drops the cycle after the detecting edge.
// - err_clr and a new error in the same cycle: error wins (stays 1).
// - bbox_valid/frame_lines latch on the VS edge that also causes an unlock; bbox_valid = 0 in that case.
// STRUCTURE
// - Package vga_mon_pkg: FSM state enum {HUNT, MEASURE, LOCKED}, TinyVGA bit-index constants, 640x480 timing defaults.
// - Sub-module vga_sync_edge: input register, polarity normalisation, HS/VS assert-edge pulses.
// - Top holds counters, FSM, bbox accumulators.
// TESTING
// - rst=1 for 2 clk mid-stream -> all outputs 0, locked=0; relock by 2nd complete frame after release.
// - Ideal 800x525 generator, white 20x20 box at (100,200) -> locked after 2nd VS edge; line_len=800, frame_lines=525,
//   bbox (100..119, 200..219), bbox_valid=1 on each frame_done.
// - While locked, one 799-clk line -> locked=0 next cycle, err_hlen=1; err_clr -> 0; relock after 2 good frames.
// - While locked, one 524-line frame -> frame_lines=524, err_vlen=1, locked=0, bbox_valid=0.
// - All-black locked frame -> bbox_valid=0; single pixel at (639,479) -> x_min=x_max=639, y_min=y_max=479.
// - tt_um_Bouncingbox uo_out in loop, 4 frames -> locked, bbox width/height constant, position steps consistent.

Source files
------------

// File: rtl/vga_mon_pkg.sv
// rtl/vga_mon_pkg.sv - shared types and constants for the TinyVGA frame monitor
package vga_mon_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  // TinyVGA Pmod bit positions: [7]HS [6]B0 [5]G0 [4]R0 [3]VS [2]B1 [1]G1 [0]R1
  localparam int BIT_HS = 7;
  localparam int BIT_B0 = 6;
  localparam int BIT_G0 = 5;
  localparam int BIT_R0 = 4;
  localparam int BIT_VS = 3;
  localparam int BIT_B1 = 2;
  localparam int BIT_G1 = 1;
  localparam int BIT_R1 = 0;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  function automatic logic sync_active(input logic level, input logic pol);
    return level == pol;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - registers the TinyVGA bus and flags HS/VS assert edges
module vga_sync_edge
  import vga_mon_pkg::*;
#(
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vga_in,
  output logic       hs_edge,
  output logic       vs_edge,
  output logic [5:0] colour
);

  logic hs_q;
  logic vs_q;
  logic hs_p;
  logic vs_p;

  // Syncs are stored already normalised to active-high so edge logic is polarity-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      hs_p   <= 1'b0;
      vs_p   <= 1'b0;
      colour <= '0;
    end else begin
      hs_q   <= sync_active(vga_in[BIT_HS], SYNC_POL);
      vs_q   <= sync_active(vga_in[BIT_VS], SYNC_POL);
      hs_p   <= hs_q;
      vs_p   <= vs_q;
      colour <= {vga_in[BIT_B0], vga_in[BIT_G0], vga_in[BIT_R0],
                 vga_in[BIT_B1], vga_in[BIT_G1], vga_in[BIT_R1]};
    end
  end

  assign hs_edge = hs_q & ~hs_p;
  assign vs_edge = vs_q & ~vs_p;

endmodule

// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - TinyVGA timing checker: line/frame measurement, lock FSM, non-black bounding box
module vga_frame_monitor
  import vga_mon_pkg::*;
#(
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_in,
  input  logic        err_clr,
  output logic        locked,
  output logic        frame_done,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        bbox_valid,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic        err_hlen,
  output logic        err_vlen
);

  localparam logic [10:0] H_TOTAL = 11'(H_VIS + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_VIS);
  localparam logic [9:0]  V_TOTAL = 10'(V_VIS + V_FP + V_SYNC + V_BP);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_VIS);

  logic        hs_edge;
  logic        vs_edge;
  logic [5:0]  colour;

  mon_state_t  state;
  mon_state_t  state_next;

  logic [10:0] h_cnt;
  logic [10:0] h_next;
  logic [10:0] len_new;
  logic [9:0]  v_cnt;
  logic [9:0]  v_line;
  logic        have_hs;
  logic        lines_ok;

  logic        any_pix;
  logic [9:0]  wx_min;
  logic [9:0]  wx_max;
  logic [9:0]  wy_min;
  logic [9:0]  wy_max;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        pix_on;

  logic        line_bad_len;
  logic        timeout;
  logic        line_bad;
  logic        frame_bad;
  logic        frame_good;

  vga_sync_edge #(
    .SYNC_POL (SYNC_POL)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .vga_in  (vga_in),
    .hs_edge (hs_edge),
    .vs_edge (vs_edge),
    .colour  (colour)
  );

  // h_next is the column of the pixel now leaving the sync stage; v_line already counts a closing HS.
  always_comb begin
    len_new = (h_cnt == '1) ? h_cnt : h_cnt + 11'd1;
    h_next  = hs_edge ? '0 : len_new;
    v_line  = (hs_edge && (v_cnt != '1)) ? v_cnt + 10'd1 : v_cnt;
    px      = 10'(h_next - H_START);
    py      = v_line - V_START;
    pix_on  = (h_next >= H_START) && (h_next < H_END) &&
              (v_line >= V_START) && (v_line < V_END) && (|colour);
  end

  always_comb begin
    line_bad_len = hs_edge && have_hs && (len_new != H_TOTAL);
    timeout      = !hs_edge && (h_next == H_TOTAL);
    line_bad     = (state == LOCKED) && (line_bad_len || timeout);
    frame_bad    = (state == LOCKED) && vs_edge && (v_line != V_TOTAL);
    frame_good   = lines_ok && !line_bad_len && (v_line == V_TOTAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (vs_edge) state_next = MEASURE;
      MEASURE: if (vs_edge && frame_good) state_next = LOCKED;
      LOCKED:  if (line_bad || frame_bad) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // Timing counters and line/frame measurement; VS handling follows HS so a shared edge closes the line first.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      have_hs     <= 1'b0;
      lines_ok    <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_done  <= 1'b0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
    end else begin
      h_cnt      <= h_next;
      frame_done <= vs_edge;

      if (hs_edge && have_hs) begin
        line_len <= len_new;
      end

      if (state_next == HUNT && state != HUNT) begin
        have_hs <= 1'b0;
      end else if (hs_edge) begin
        have_hs <= 1'b1;
      end

      if (vs_edge) begin
        v_cnt       <= '0;
        frame_lines <= v_line;
        lines_ok    <= 1'b1;
      end else begin
        v_cnt <= v_line;
        if (line_bad_len) begin
          lines_ok <= 1'b0;
        end
      end

      err_hlen <= line_bad || (err_hlen && !err_clr);
      err_vlen <= frame_bad || (err_vlen && !err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_pix    <= 1'b0;
      wx_min     <= '0;
      wx_max     <= '0;
      wy_min     <= '0;
      wy_max     <= '0;
      bbox_valid <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
    end else if (vs_edge) begin
      bbox_valid <= (state == LOCKED) && !line_bad && !frame_bad && any_pix;
      x_min      <= wx_min;
      x_max      <= wx_max;
      y_min      <= wy_min;
      y_max      <= wy_max;
      any_pix    <= 1'b0;
      wx_min     <= '1;
      wx_max     <= '0;
      wy_min     <= '1;
      wy_max     <= '0;
    end else if (pix_on) begin
      any_pix <= 1'b1;
      if (px < wx_min) wx_min <= px;
      if (px > wx_max) wx_max <= px;
      if (py < wy_min) wy_min <= py;
      if (py > wy_max) wy_max <= py;
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - directed bench for vga_frame_monitor on a reduced 25x17 raster
module tb_vga_frame_monitor;

  localparam int HV = 16, HFP = 2, HSY = 4, HBP = 3;
  localparam int VV = 12, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HV + HFP + HSY + HBP;
  localparam int VT = VV + VFP + VSY + VBP;
  localparam int HOFF = HSY + HBP;
  localparam int VOFF = VSY + VBP;
  localparam logic [7:0] IDLE = 8'h88;

  logic        clk;
  logic        rst;
  logic [7:0]  vga_in;
  logic        err_clr;
  logic        locked;
  logic        frame_done;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic        bbox_valid;
  logic [9:0]  x_min, x_max, y_min, y_max;
  logic        err_hlen;
  logic        err_vlen;

  int n_checks = 0;
  int n_fail = 0;

  int          fd_cnt = 0;
  logic        last_locked, last_bv;
  logic [9:0]  last_lines, last_xmin, last_xmax, last_ymin, last_ymax;
  logic [10:0] last_len;
  int          drop_cnt = 0;
  logic        drop_eh, drop_ev, drop_bv, locked_q = 1'b0;
  logic [10:0] drop_len;
  logic [9:0]  drop_lines;

  vga_frame_monitor #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_in      (vga_in),
    .err_clr     (err_clr),
    .locked      (locked),
    .frame_done  (frame_done),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .bbox_valid  (bbox_valid),
    .x_min       (x_min),
    .x_max       (x_max),
    .y_min       (y_min),
    .y_max       (y_max),
    .err_hlen    (err_hlen),
    .err_vlen    (err_vlen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      last_locked = locked;
      last_bv     = bbox_valid;
      last_lines  = frame_lines;
      last_len    = line_len;
      last_xmin   = x_min;
      last_xmax   = x_max;
      last_ymin   = y_min;
      last_ymax   = y_max;
    end
    if (locked_q && !locked) begin
      drop_cnt++;
      drop_len   = line_len;
      drop_lines = frame_lines;
      drop_eh    = err_hlen;
      drop_ev    = err_vlen;
      drop_bv    = bbox_valid;
    end
    locked_q = locked;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_locked"}, locked, 0);
    check_eq({pfx, "_frame_done"}, frame_done, 0);
    check_eq({pfx, "_line_len"}, line_len, 0);
    check_eq({pfx, "_frame_lines"}, frame_lines, 0);
    check_eq({pfx, "_bbox_valid"}, bbox_valid, 0);
    check_eq({pfx, "_x_min"}, x_min, 0);
    check_eq({pfx, "_x_max"}, x_max, 0);
    check_eq({pfx, "_y_min"}, y_min, 0);
    check_eq({pfx, "_y_max"}, y_max, 0);
    check_eq({pfx, "_err_hlen"}, err_hlen, 0);
    check_eq({pfx, "_err_vlen"}, err_vlen, 0);
  endtask

  task automatic check_bbox(input string pfx, input int x0, input int x1, input int y0, input int y1);
    check_eq({pfx, "_bv"}, last_bv, 1);
    check_eq({pfx, "_xmin"}, last_xmin, x0);
    check_eq({pfx, "_xmax"}, last_xmax, x1);
    check_eq({pfx, "_ymin"}, last_ymin, y0);
    check_eq({pfx, "_ymax"}, last_ymax, y1);
  endtask

  // Raster starts each line at HS assert and each frame at VS assert; box coords are visible-area based.
  task automatic send_frame(input int n_lines, input int short_vc,
                            input int bx, input int by, input int bw, input int bh);
    for (int vc = 0; vc < n_lines; vc++) begin
      int len;
      len = (vc == short_vc) ? HT - 1 : HT;
      for (int hc = 0; hc < len; hc++) begin
        int x, y;
        logic hs, vs, on;
        x  = hc - HOFF;
        y  = vc - VOFF;
        hs = (hc < HSY) ? 1'b0 : 1'b1;
        vs = (vc < VSY) ? 1'b0 : 1'b1;
        on = (x >= 0) && (x < HV) && (y >= 0) && (y < VV) &&
             (x >= bx) && (x < bx + bw) && (y >= by) && (y < by + bh);
        @(negedge clk);
        vga_in = {hs, on ? 3'b111 : 3'b000, vs, on ? 3'b111 : 3'b000};
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    vga_in = IDLE;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst0");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(VT, -1, 5, 4, 3, 3);
    check_eq("f1_locked", locked, 0);
    send_frame(VT, -1, 5, 4, 3, 3);
    check_eq("f2_locked", locked, 1);
    check_eq("f1c_locked", last_locked, 1);
    check_eq("f1c_lines", last_lines, VT);
    check_eq("f1c_len", last_len, HT);
    check_eq("f1c_bv", last_bv, 0);
    send_frame(VT, -1, 5, 4, 3, 3);
    check_eq("fd_cnt3", fd_cnt, 3);
    check_bbox("box", 5, 7, 4, 6);

    send_frame(VT, 5, 5, 4, 3, 3);
    check_eq("hl_locked", locked, 0);
    check_eq("hl_err", err_hlen, 1);
    check_eq("hl_drops", drop_cnt, 1);
    check_eq("hl_drop_len", drop_len, HT - 1);
    check_eq("hl_drop_eh", drop_eh, 1);
    @(negedge clk);
    err_clr = 1'b1;
    vga_in = IDLE;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("hl_clr", err_hlen, 0);

    send_frame(VT, -1, 5, 4, 3, 3);
    send_frame(VT, -1, 5, 4, 3, 3);
    check_eq("relock_locked", locked, 1);
    check_eq("relock_bv", last_bv, 0);
    send_frame(VT - 1, -1, 5, 4, 3, 3);
    check_bbox("relock_box", 5, 7, 4, 6);

    send_frame(VT, -1, 0, 0, 0, 0);
    check_eq("vl_lines", last_lines, VT - 1);
    check_eq("vl_bv", last_bv, 0);
    check_eq("vl_locked", last_locked, 0);
    check_eq("vl_err", err_vlen, 1);
    check_eq("vl_errh", err_hlen, 0);
    check_eq("vl_drops", drop_cnt, 2);
    check_eq("vl_drop_lines", drop_lines, VT - 1);
    check_eq("vl_drop_ev", drop_ev, 1);
    check_eq("vl_drop_bv", drop_bv, 0);

    send_frame(VT, -1, 0, 0, 0, 0);
    send_frame(VT, -1, 0, 0, 0, 0);
    send_frame(VT, -1, HV - 1, VV - 1, 1, 1);
    check_eq("black_locked", last_locked, 1);
    check_eq("black_bv", last_bv, 0);

    for (int k = 0; k < 4; k++) begin
      send_frame(VT, -1, 2 + 3 * k, 1 + 2 * k, 3, 2);
      if (k == 0) begin
        check_bbox("corner", HV - 1, HV - 1, VV - 1, VV - 1);
      end else begin
        check_bbox($sformatf("bounce%0d", k - 1), 2 + 3 * (k - 1), 4 + 3 * (k - 1),
                   1 + 2 * (k - 1), 2 + 2 * (k - 1));
        check_eq($sformatf("bounce%0d_w", k - 1), 32'(last_xmax - last_xmin) + 1, 3);
      end
    end
    send_frame(8, -1, 0, 0, 0, 0);
    check_bbox("bounce3", 11, 13, 7, 8);
    check_eq("fd_cnt16", fd_cnt, 16);
    check_eq("pre_rst_locked", locked, 1);

    rst = 1'b1;
    vga_in = IDLE;
    repeat (2) @(negedge clk);
    check_zero("rst_mid");
    rst = 1'b0;
    send_frame(VT, -1, 5, 4, 3, 3);
    check_eq("rst_f1_locked", locked, 0);
    send_frame(VT, -1, 5, 4, 3, 3);
    check_eq("rst_relock", locked, 1);
    check_eq("rst_relock_lines", last_lines, VT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
